// File: rtl/winit_pkg.sv
// Shared types and constants for the weight initialisation sequencer.
// Holds the FSM state enum, LFSR geometry and the feedback tap mask.
package winit_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_TICK,
    WRITE,
    DONE
  } winit_state_t;

  localparam int          LFSR_W       = 16;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;
  // Taps at bits 15, 13, 12, 10 : x^16 + x^14 + x^13 + x^11 + 1
  localparam logic [15:0] LFSR_TAPS    = 16'hB400;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] l);
    return {l[LFSR_W-2:0], ^(l & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/winit_lfsr.sv
// 16-bit Fibonacci LFSR: load has priority over step; resets to RST_VAL.
// Output q is the current register value, available the cycle after load/step.
module winit_lfsr
  import winit_pkg::*;
#(
  parameter logic [LFSR_W-1:0] RST_VAL = DEFAULT_SEED
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [LFSR_W-1:0] seed,
  input  logic              step,
  output logic [LFSR_W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= RST_VAL;
    end else if (load) begin
      q <= seed;
    end else if (step) begin
      q <= lfsr_next(q);
    end
  end

endmodule

// File: rtl/weight_init_seq.sv
// Writes N_WEIGHTS pseudo-random weights, one per rising edge of slow_clk.
// Optional WINIT_SCALE_EN macro: arithmetic right-shift of each weight by SHIFT.
module weight_init_seq
  import winit_pkg::*;
#(
  parameter int          ADDR_W    = 6,
  parameter int          DATA_W    = 8,
  parameter int          N_WEIGHTS = 40,
  parameter logic [15:0] SEED      = 16'hACE1,
  parameter int          SHIFT     = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              slow_clk,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [DATA_W-1:0] wdata
);

  localparam logic [LFSR_W-1:0] EFF_SEED = (SEED == 16'd0) ? DEFAULT_SEED : SEED;
  localparam logic [ADDR_W-1:0] LAST     = ADDR_W'(N_WEIGHTS - 1);

  winit_state_t      state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              slow_d;
  logic              tick;
  logic              lfsr_load;
  logic              lfsr_step;
  logic [LFSR_W-1:0] lfsr_q;

  // slow_d resets high to match the divider's reset-high output: no tick after reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slow_d  <= 1'b1;
      state_q <= IDLE;
      addr_q  <= '0;
    end else begin
      slow_d  <= slow_clk;
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  assign tick = slow_clk & ~slow_d;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    lfsr_load = 1'b0;
    lfsr_step = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          lfsr_load = 1'b1;
          addr_d    = '0;
          state_d   = WAIT_TICK;
        end
      end
      WAIT_TICK: begin
        if (tick) state_d = WRITE;
      end
      WRITE: begin
        lfsr_step = 1'b1;
        if (addr_q == LAST) begin
          state_d = DONE;
        end else begin
          addr_d  = addr_q + 1'b1;
          state_d = WAIT_TICK;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  winit_lfsr #(
    .RST_VAL(EFF_SEED)
  ) u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .load (lfsr_load),
    .seed (EFF_SEED),
    .step (lfsr_step),
    .q    (lfsr_q)
  );

  assign we    = (state_q == WRITE);
  assign busy  = (state_q == WAIT_TICK) || (state_q == WRITE);
  assign done  = (state_q == DONE);
  assign waddr = addr_q;

`ifdef WINIT_SCALE_EN
  assign wdata = DATA_W'($signed(lfsr_q[DATA_W-1:0]) >>> SHIFT);
`else
  localparam int unused_shift = SHIFT;
  assign wdata = lfsr_q[DATA_W-1:0];
`endif

  logic unused_lfsr_hi;
  assign unused_lfsr_hi = ^(lfsr_q >> DATA_W);

endmodule

// File: tb/tb_weight_init_seq.sv
// Randomised bench for weight_init_seq against a transaction-level model of the write sequence.
// Covers reset, idle toggling, full passes, ignored starts, start+tick coincidence and mid-pass reset.
module tb_weight_init_seq;

  localparam int          ADDR_W    = 6;
  localparam int          DATA_W    = 8;
  localparam int          N_WEIGHTS = 40;
  localparam logic [15:0] SEED      = 16'hACE1;
  localparam int          SHIFT     = 2;
`ifdef WINIT_SCALE_EN
  localparam logic [7:0] FIRST_W  = 8'hF8;
  localparam logic [7:0] SECOND_W = 8'hF0;
`else
  localparam logic [7:0] FIRST_W  = 8'hE1;
  localparam logic [7:0] SECOND_W = 8'hC3;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              slow_clk;
  logic              start;
  logic              busy;
  logic              done;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;

  always #5 clk = ~clk;

  weight_init_seq #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .N_WEIGHTS(N_WEIGHTS), .SEED(SEED), .SHIFT(SHIFT)
  ) dut (
    .clk(clk), .rst(rst), .slow_clk(slow_clk), .start(start),
    .busy(busy), .done(done), .we(we), .waddr(waddr), .wdata(wdata)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Model: a pass is a list of N writes; write k carries address k and the k-th LFSR state
  bit m_running, m_done, m_we, m_slow_prev;
  int m_idx;
  int pulses;
  int period, phase;
  bit rand_period;

  function automatic logic [15:0] lfsr_at(input int k);
    logic [15:0] l;
    l = SEED;
    for (int i = 0; i < k; i++) l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    return l;
  endfunction

  function automatic logic [7:0] exp_w(input int k);
    logic [15:0]       l;
    logic signed [7:0] s;
    l = lfsr_at(k);
    s = l[7:0];
`ifdef WINIT_SCALE_EN
    return s >>> SHIFT;
`else
    return s;
`endif
  endfunction

  task automatic model_reset();
    m_running   = 1'b0;
    m_done      = 1'b0;
    m_we        = 1'b0;
    m_idx       = 0;
    m_slow_prev = 1'b1;
  endtask

  // Called at a negedge: check outputs, drive next inputs, advance model, wait one cycle
  task automatic cycle(input bit st);
    bit tick;
    check("we", we, m_we);
    check("busy", busy, m_running);
    check("done", done, m_done);
    if (we) pulses++;
    if (m_we) begin
      check("waddr", waddr, m_idx);
      check("wdata", wdata, exp_w(m_idx));
      if (m_idx == 0) check("first_wdata", wdata, FIRST_W);
      if (m_idx == 1) check("second_wdata", wdata, SECOND_W);
    end
    phase++;
    if (phase >= period) begin
      phase = 0;
      if (rand_period) period = $urandom_range(2, 7);
    end
    slow_clk = (phase < period / 2);
    start    = st;
    tick        = slow_clk && !m_slow_prev;
    m_slow_prev = slow_clk;
    if (m_we) begin
      m_we = 1'b0;
      m_idx++;
      if (m_idx == N_WEIGHTS) begin
        m_running = 1'b0;
        m_done    = 1'b1;
        check("pass_pulses", pulses, N_WEIGHTS);
      end
    end else if (!m_running) begin
      if (st) begin
        m_running = 1'b1;
        m_done    = 1'b0;
        m_idx     = 0;
        pulses    = 0;
      end
    end else if (tick) begin
      m_we = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic run_pass();
    for (int i = 0; i < 3000 && !m_done; i++)
      cycle(m_running && ($urandom_range(0, 7) == 0));
    check("pass_timeout", m_done, 1);
  endtask

  initial begin
    rst         = 1'b1;
    slow_clk    = 1'b1;
    start       = 1'b0;
    pulses      = 0;
    period      = 4;
    phase       = 0;
    rand_period = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_we", we, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_waddr", waddr, 0);
    check("rst_wdata", wdata, FIRST_W);
    rst = 1'b0;

    // Idle toggling: never writes
    repeat (30) cycle(1'b0);

    // Full pass at divider period 5 with stray mid-pass starts
    period = 5;
    cycle(1'b1);
    run_pass();
    repeat (10) cycle(1'b0);

    // Start coincident with a slow_clk rising edge from DONE, random divider periods
    rand_period = 1'b1;
    for (int i = 0; i < 20 && phase != period - 1; i++) cycle(1'b0);
    check("coincide_align", phase, period - 1);
    cycle(1'b1);
    run_pass();

    // Reset while waiting at address 17
    cycle(1'b1);
    for (int i = 0; i < 3000 && !(m_running && !m_we && m_idx == 17); i++) cycle(1'b0);
    check("reach_addr17", m_idx, 17);
    #2 rst = 1'b1;
    #1;
    check("midrst_we", we, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("postrst_waddr", waddr, 0);
    check("postrst_wdata", wdata, FIRST_W);
    repeat (3) cycle(1'b0);
    cycle(1'b1);
    run_pass();
    repeat (5) cycle(1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
